hit_readout_unpacker: RTL and testbench
=======================================

# hit_readout_unpacker

Downstream consumer of the hit memory block (`hxmpp`) read port. It accepts SSID read requests over a valid/ready handshake and issues single-cycle `read` pulses to `hxmpp`. It captures the packed return (`readFinished`, SSID, `hitThisEvent`, `nHits`, `hitInfo`) and serialises the stored hit words onto a one-hit-per-beat output stream for the track-fitting side. It also flags timeouts, SSID mismatches and hit-count overflow.

## Interface
Parameters:
- `SSIDBITS`, 8: SSID width.
- `HITINFOBITS`, 8: width of one hit word.
- `MAXHITNBITS`, 3: width of `nHits`.
- `MAXHITS`, 4: hit words packed in `hitInfo`; `hitInfo` width = `MAXHITS*HITINFOBITS`.
- `TIMEOUT`, 64: cycles to wait for `readFinished` before abandoning a read.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, 1: request SSID available.
- `req_ready`, out, 1: block can accept a request.
- `req_ssid`, in, `SSIDBITS`: SSID to read.
- `read`, out, 1: read strobe to `hxmpp`.
- `readSSID`, out, `SSIDBITS`: SSID presented with `read`.
- `readFinished`, in, 1: `hxmpp` return strobe.
- `SSID_readReturn`, in, `SSIDBITS`: returned SSID.
- `hitThisEventReturn`, in, 1: SSID was hit this event.
- `nHitsReturn`, in, `MAXHITNBITS`: stored hit count.
- `hitInfo_readReturn`, in, `MAXHITS*HITINFOBITS`: packed hit words; word k is bits [k*HITINFOBITS +: HITINFOBITS].
- `out_valid`, out, 1: output beat valid.
- `out_ready`, in, 1: downstream accepts beat.
- `out_ssid`, out, `SSIDBITS`: SSID of current record.
- `out_hit`, out, `HITINFOBITS`: current hit word.
- `out_last`, out, 1: final beat of record.
- `out_empty`, out, 1: record carries no hits (`out_hit` = 0).
- `err_timeout`, out, 1: one-cycle pulse on timeout.
- `err_mismatch`, out, 1: one-cycle pulse when returned SSID ≠ requested.
- `err_overflow`, out, 1: one-cycle pulse when `nHitsReturn` > `MAXHITS`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, EMIT.
- `req_ready` = (state == IDLE), combinational.
- IDLE: on `req_valid && req_ready`, latch `req_ssid` into `readSSID`, go to ISSUE.
- ISSUE: `read` = 1 for exactly this cycle; clear timeout counter; go to WAIT.
- WAIT: `read` = 0; counter increments each cycle.
  - On `readFinished`: capture all return fields and go to EMIT.
  - If `SSID_readReturn` ≠ latched SSID: pulse `err_mismatch`; data is still emitted under the requested SSID.
  - If the counter reaches `TIMEOUT-1` without `readFinished`: pulse `err_timeout`, emit nothing, return to IDLE.
  - `readFinished` takes priority over timeout in the same cycle.
- Capture rules:
  - effective count n = 0 if `hitThisEventReturn` = 0.
  - Otherwise n = min(`nHitsReturn`, `MAXHITS`).
  - Pulse `err_overflow` when clamping occurs.
- EMIT, n = 0: single beat with `out_empty` = 1, `out_last` = 1, `out_hit` = 0.
- EMIT, n > 0: n beats carrying words 0..n-1 in ascending order; `out_last` = 1 on word n-1.
- Beat index advances only on `out_valid && out_ready`; output fields are stable while stalled.
- After the last beat is accepted, go to IDLE. The next request can be accepted on the following cycle.
- `readFinished` in IDLE, ISSUE or EMIT is ignored.
- Beat index counter width is ceil(log2(`MAXHITS`+1)). `nHitsReturn` is compared zero-extended.

## Timing
- All outputs are registered except `req_ready`.
- Reset values:
  - state IDLE, so `req_ready` = 1;
  - `read` = 0, `readSSID` = 0;
  - `out_valid` = 0, `out_ssid` = 0, `out_hit` = 0, `out_last` = 0, `out_empty` = 0;
  - all `err_*` = 0; counters = 0.
- Request accepted at edge T: `read` is high during cycle T+1 with `readSSID` valid.
- `readFinished` sampled at edge R: `out_valid` is high from cycle R+1.
- Unstalled throughput: one beat per cycle.
- Record turnaround: last beat accepted at edge E → `req_ready` = 1 in cycle E+1.
- Error pulses assert for exactly one cycle, in the cycle after the triggering edge.
- Reset asserted mid-operation: outputs go to reset values immediately; captured data and any in-flight read are discarded. A later `readFinished` is ignored until a new request is issued.

## Test plan
- Reset, then request SSID 0x84, `hxmpp` returns after 3 cycles with hit = 1, nHits = 3, words {0x11, 0x22, 0x33} → `read` pulse one cycle after accept; 3 beats 0x11, 0x22, 0x33 on ssid 0x84, `out_last` on 0x33.
- Request 0x48 returning hit = 0, nHits = 2 → one beat, `out_empty` = 1, `out_last` = 1, `out_hit` = 0.
- nHits = 6 with `MAXHITS` = 4 → `err_overflow` pulse; exactly 4 beats, words 0..3.
- No `readFinished` for 64 cycles → `err_timeout` pulse at the 64th WAIT cycle; no output beats; `req_ready` = 1 on the next cycle.
- Returned SSID 0x85 for request 0x84, nHits = 1 → `err_mismatch` pulse; one beat with `out_ssid` = 0x84.
- `out_ready` low for 5 cycles mid-record, then reset asserted during EMIT → fields held stable while stalled; reset drives `out_valid` = 0 and `req_ready` = 1 asynchronously.

Source files
------------

// File: rtl/hit_readout_unpacker.sv
// Read-port consumer for hxmpp: issues SSID reads, captures the packed
// return and streams the stored hit words out one per beat.
module hit_readout_unpacker #(
  parameter int SSIDBITS    = 8,
  parameter int HITINFOBITS = 8,
  parameter int MAXHITNBITS = 3,
  parameter int MAXHITS     = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [SSIDBITS-1:0]            req_ssid,
  output logic                           read,
  output logic [SSIDBITS-1:0]            readSSID,
  input  logic                           readFinished,
  input  logic [SSIDBITS-1:0]            SSID_readReturn,
  input  logic                           hitThisEventReturn,
  input  logic [MAXHITNBITS-1:0]         nHitsReturn,
  input  logic [MAXHITS*HITINFOBITS-1:0] hitInfo_readReturn,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SSIDBITS-1:0]            out_ssid,
  output logic [HITINFOBITS-1:0]         out_hit,
  output logic                           out_last,
  output logic                           out_empty,
  output logic                           err_timeout,
  output logic                           err_mismatch,
  output logic                           err_overflow
);

  localparam int CW = $clog2(MAXHITS + 1);
  localparam int NW = (MAXHITNBITS > CW) ? MAXHITNBITS : CW;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int HW = MAXHITS * HITINFOBITS;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

  state_t                 state, stateNext;
  logic [TW-1:0]          cnt, cntNext;
  logic [CW-1:0]          idx, idxNext;
  logic [CW-1:0]          nEff, nEffNext;
  logic [HW-1:0]          hitBuf, hitBufNext;
  logic                   readNext;
  logic [SSIDBITS-1:0]    readSSIDNext;
  logic                   outValidNext;
  logic [SSIDBITS-1:0]    outSsidNext;
  logic [HITINFOBITS-1:0] outHitNext;
  logic                   outLastNext;
  logic                   outEmptyNext;
  logic                   errTimeoutNext;
  logic                   errMismatchNext;
  logic                   errOverflowNext;
  logic [NW-1:0]          nRet;
  logic                   clamp;
  logic [CW-1:0]          nCap;

  function automatic logic [HITINFOBITS-1:0] wordAt(
    input logic [HW-1:0] v,
    input logic [CW-1:0] k
  );
    logic [HITINFOBITS-1:0] w;
    w = '0;
    for (int i = 0; i < MAXHITS; i++)
      if (CW'(i) == k) w = v[i*HITINFOBITS +: HITINFOBITS];
    return w;
  endfunction

  assign req_ready = (state == IDLE);

  // Effective hit count: misses carry nothing, overfull lists are clamped
  always_comb begin
    nRet  = NW'(nHitsReturn);
    clamp = hitThisEventReturn && (nRet > NW'(MAXHITS));
    if (!hitThisEventReturn) nCap = '0;
    else if (clamp)          nCap = CW'(MAXHITS);
    else                     nCap = CW'(nRet);
  end

  always_comb begin
    stateNext       = state;
    cntNext         = cnt;
    idxNext         = idx;
    nEffNext        = nEff;
    hitBufNext      = hitBuf;
    readNext        = 1'b0;
    readSSIDNext    = readSSID;
    outValidNext    = out_valid;
    outSsidNext     = out_ssid;
    outHitNext      = out_hit;
    outLastNext     = out_last;
    outEmptyNext    = out_empty;
    errTimeoutNext  = 1'b0;
    errMismatchNext = 1'b0;
    errOverflowNext = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          readSSIDNext = req_ssid;
          readNext     = 1'b1;
          stateNext    = ISSUE;
        end
      end
      ISSUE: begin
        cntNext   = '0;
        stateNext = WAIT;
      end
      WAIT: begin
        if (readFinished) begin
          hitBufNext      = hitInfo_readReturn;
          nEffNext        = nCap;
          idxNext         = '0;
          errMismatchNext = (SSID_readReturn != readSSID);
          errOverflowNext = clamp;
          outValidNext    = 1'b1;
          outSsidNext     = readSSID;
          outHitNext      = (nCap == '0) ? '0
                          : hitInfo_readReturn[HITINFOBITS-1:0];
          outLastNext     = (nCap <= CW'(1));
          outEmptyNext    = (nCap == '0);
          stateNext       = EMIT;
        end else if (cnt == TW'(TIMEOUT - 1)) begin
          errTimeoutNext = 1'b1;
          stateNext      = IDLE;
        end else begin
          cntNext = cnt + TW'(1);
        end
      end
      EMIT: begin
        if (out_valid && out_ready) begin
          if (out_last) begin
            outValidNext = 1'b0;
            outHitNext   = '0;
            outLastNext  = 1'b0;
            outEmptyNext = 1'b0;
            stateNext    = IDLE;
          end else begin
            idxNext     = idx + CW'(1);
            outHitNext  = wordAt(hitBuf, idx + CW'(1));
            outLastNext = (idx + CW'(2) == nEff);
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      nEff         <= '0;
      hitBuf       <= '0;
      read         <= 1'b0;
      readSSID     <= '0;
      out_valid    <= 1'b0;
      out_ssid     <= '0;
      out_hit      <= '0;
      out_last     <= 1'b0;
      out_empty    <= 1'b0;
      err_timeout  <= 1'b0;
      err_mismatch <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state        <= stateNext;
      cnt          <= cntNext;
      idx          <= idxNext;
      nEff         <= nEffNext;
      hitBuf       <= hitBufNext;
      read         <= readNext;
      readSSID     <= readSSIDNext;
      out_valid    <= outValidNext;
      out_ssid     <= outSsidNext;
      out_hit      <= outHitNext;
      out_last     <= outLastNext;
      out_empty    <= outEmptyNext;
      err_timeout  <= errTimeoutNext;
      err_mismatch <= errMismatchNext;
      err_overflow <= errOverflowNext;
    end
  end

endmodule

// File: tb/tb_hit_readout_unpacker.sv
// Directed plus randomized bench for hit_readout_unpacker against a
// record-level reference model.
module tb_hit_readout_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_ssid;
  logic        read;
  logic [7:0]  readSSID;
  logic        readFinished;
  logic [7:0]  SSID_readReturn;
  logic        hitThisEventReturn;
  logic [2:0]  nHitsReturn;
  logic [31:0] hitInfo_readReturn;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_ssid;
  logic [7:0]  out_hit;
  logic        out_last;
  logic        out_empty;
  logic        err_timeout;
  logic        err_mismatch;
  logic        err_overflow;

  hit_readout_unpacker dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_ssid(req_ssid),
    .read(read), .readSSID(readSSID),
    .readFinished(readFinished), .SSID_readReturn(SSID_readReturn),
    .hitThisEventReturn(hitThisEventReturn), .nHitsReturn(nHitsReturn),
    .hitInfo_readReturn(hitInfo_readReturn),
    .out_valid(out_valid), .out_ready(out_ready), .out_ssid(out_ssid),
    .out_hit(out_hit), .out_last(out_last), .out_empty(out_empty),
    .err_timeout(err_timeout), .err_mismatch(err_mismatch),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int nChk = 0;
  int nFail = 0;

  logic [7:0] expHit[$];
  logic       expLast[$];
  logic       expEmpty[$];
  logic       expMis;
  logic       expOvf;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nChk++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: what one record should look like on the output stream
  task automatic model(input logic [7:0] req, input logic [7:0] rs,
                       input logic h, input logic [2:0] nh,
                       input logic [31:0] info);
    int n;
    expHit.delete();
    expLast.delete();
    expEmpty.delete();
    n = h ? ((int'(nh) > 4) ? 4 : int'(nh)) : 0;
    expMis = (rs != req);
    expOvf = h && (int'(nh) > 4);
    if (n == 0) begin
      expHit.push_back(8'h00);
      expLast.push_back(1'b1);
      expEmpty.push_back(1'b1);
    end else begin
      for (int i = 0; i < n; i++) begin
        expHit.push_back(info[8*i +: 8]);
        expLast.push_back(i == n - 1);
        expEmpty.push_back(1'b0);
      end
    end
  endtask

  task automatic issue(input logic [7:0] s);
    req_valid = 1'b1;
    req_ssid  = s;
    chk("req_ready_idle", req_ready, 1);
    tick();
    req_valid = 1'b0;
    req_ssid  = 8'($urandom);
    chk("read_pulse", read, 1);
    chk("readSSID", readSSID, s);
    chk("req_ready_busy", req_ready, 0);
    tick();
    chk("read_drop", read, 0);
  endtask

  task automatic respond(input int d, input logic [7:0] rs, input logic h,
                         input logic [2:0] nh, input logic [31:0] info);
    repeat (d - 1) begin
      chk("wait_no_valid", out_valid, 0);
      tick();
    end
    readFinished       = 1'b1;
    SSID_readReturn    = rs;
    hitThisEventReturn = h;
    nHitsReturn        = nh;
    hitInfo_readReturn = info;
    tick();
    readFinished       = 1'b0;
    SSID_readReturn    = 8'($urandom);
    hitThisEventReturn = 1'($urandom);
    nHitsReturn        = 3'($urandom);
    hitInfo_readReturn = $urandom;
  endtask

  task automatic drain(input logic [7:0] s, input int stallPct);
    int  k = 0;
    int  budget = 400;
    bit  first = 1'b1;
    while (k < expHit.size() && budget > 0) begin
      out_ready = ($urandom_range(99) >= stallPct);
      chk("out_valid", out_valid, 1);
      chk("out_ssid", out_ssid, s);
      chk("out_hit", out_hit, expHit[k]);
      chk("out_last", out_last, expLast[k]);
      chk("out_empty", out_empty, expEmpty[k]);
      chk("err_mismatch", err_mismatch, first ? expMis : 1'b0);
      chk("err_overflow", err_overflow, first ? expOvf : 1'b0);
      chk("err_timeout_emit", err_timeout, 0);
      first = 1'b0;
      tick();
      if (out_ready) k++;
      budget--;
    end
    if (budget == 0) chk("drain_budget", 0, 1);
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_ready", req_ready, 1);
  endtask

  task automatic record(input logic [7:0] req, input logic [7:0] rs,
                        input logic h, input logic [2:0] nh,
                        input logic [31:0] info, input int d,
                        input int stallPct);
    model(req, rs, h, nh, info);
    issue(req);
    respond(d, rs, h, nh, info);
    drain(req, stallPct);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_ssid = 8'h00;
    readFinished = 1'b0;
    SSID_readReturn = 8'h00;
    hitThisEventReturn = 1'b0;
    nHitsReturn = 3'd0;
    hitInfo_readReturn = 32'h0;
    out_ready = 1'b0;
    repeat (2) tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_read", read, 0);
    chk("rst_readSSID", readSSID, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ssid", out_ssid, 0);
    chk("rst_out_hit", out_hit, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_empty", out_empty, 0);
    chk("rst_errs", {err_timeout, err_mismatch, err_overflow}, 0);
    reset = 1'b0;
    tick();

    record(8'h84, 8'h84, 1'b1, 3'd3, 32'h00332211, 3, 0);
    record(8'h48, 8'h48, 1'b0, 3'd2, 32'hDEADBEEF, 2, 0);
    record(8'h21, 8'h21, 1'b1, 3'd6, 32'h44332211, 1, 0);
    record(8'h84, 8'h85, 1'b1, 3'd1, 32'h000000A5, 4, 0);
    record(8'h66, 8'h66, 1'b1, 3'd4, 32'h0D0C0B0A, 64, 0);
    record(8'h55, 8'h55, 1'b1, 3'd0, 32'hFFFFFFFF, 1, 0);

    issue(8'h10);
    for (int c = 1; c <= 64; c++) begin
      chk("to_quiet", err_timeout, 0);
      chk("to_no_valid", out_valid, 0);
      chk("to_busy", req_ready, 0);
      tick();
    end
    chk("to_pulse", err_timeout, 1);
    chk("to_ready", req_ready, 1);
    chk("to_no_valid_after", out_valid, 0);
    tick();
    chk("to_pulse_end", err_timeout, 0);

    readFinished = 1'b1;
    hitThisEventReturn = 1'b1;
    nHitsReturn = 3'd2;
    tick();
    readFinished = 1'b0;
    chk("idle_rf_ignored", out_valid, 0);
    chk("idle_rf_ready", req_ready, 1);

    model(8'h33, 8'h33, 1'b1, 3'd4, 32'hA1B2C3D4);
    issue(8'h33);
    respond(2, 8'h33, 1'b1, 3'd4, 32'hA1B2C3D4);
    out_ready = 1'b1;
    chk("rs_beat0", out_hit, expHit[0]);
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_hit", out_hit, expHit[1]);
      chk("stall_last", out_last, 0);
      chk("stall_ssid", out_ssid, 8'h33);
      tick();
    end
    #3 reset = 1'b1;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_ready", req_ready, 1);
    chk("async_hit", out_hit, 0);
    chk("async_ssid", out_ssid, 0);
    chk("async_readSSID", readSSID, 0);
    tick();
    reset = 1'b0;
    readFinished = 1'b1;
    hitThisEventReturn = 1'b1;
    nHitsReturn = 3'd3;
    SSID_readReturn = 8'h33;
    tick();
    readFinished = 1'b0;
    chk("late_rf_ignored", out_valid, 0);
    tick();
    chk("late_rf_ignored2", out_valid, 0);
    chk("late_rf_ready", req_ready, 1);

    for (int t = 0; t < 25; t++) begin
      logic [7:0] rq;
      logic [7:0] rs;
      rq = 8'($urandom);
      rs = ($urandom_range(3) == 0) ? (rq ^ 8'($urandom_range(1, 255))) : rq;
      record(rq, rs, 1'($urandom_range(3) != 0), 3'($urandom),
             $urandom, $urandom_range(1, 10), 30);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChk, nFail);
    $finish;
  end

endmodule
